// File: rtl/alu_exec_ctrl_pkg.sv
// Shared definitions for the ALU issue/writeback controller:
// ALU control codes, instruction opcode/ext codes, PSR bit positions
// and the controller FSM state encoding.
package alu_exec_ctrl_pkg;

    // ALU control codes driven on aluControl
    typedef enum logic [3:0] {
        ALU_NOP  = 4'b0000,
        ALU_SUB  = 4'b0001,
        ALU_CMP  = 4'b0010,
        ALU_AND  = 4'b0011,
        ALU_OR   = 4'b0100,
        ALU_XOR  = 4'b0101,
        ALU_MOV  = 4'b0110,
        ALU_MOVI = 4'b0111,
        ALU_ADD  = 4'b1000
    } alu_op_e;

    // Opcode 0000 selects register format; the operation then comes from ext.
    localparam logic [3:0] OP_RTYPE = 4'b0000;

    // Operation codes: used as ext in register format and as the opcode
    // itself in immediate format.
    typedef enum logic [3:0] {
        EXT_AND = 4'b0001,
        EXT_OR  = 4'b0010,
        EXT_XOR = 4'b0011,
        EXT_ADD = 4'b0101,
        EXT_SUB = 4'b1001,
        EXT_CMP = 4'b1011,
        EXT_MOV = 4'b1101
    } ext_e;

    // PSR bit positions, psr = {N,Z,F,L,C}
    localparam int unsigned PSR_C = 0;
    localparam int unsigned PSR_L = 1;
    localparam int unsigned PSR_F = 2;
    localparam int unsigned PSR_Z = 3;
    localparam int unsigned PSR_N = 4;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_DECODE    = 2'd1,
        ST_EXECUTE   = 2'd2,
        ST_WRITEBACK = 2'd3
    } state_e;

endpackage

// File: rtl/alu_exec_ctrl_instr_decode.sv
// Combinational instruction decoder.
// Ports:
//   instr       in   16-bit instruction word
//   aluControl  out  ALU operation code
//   imm         out  extended immediate (0 for register format / illegal)
//   a_imm_sel   out  ALU a takes imm
//   b_imm_sel   out  ALU b takes imm (MOVI only)
//   writes_rf   out  instruction writes Rdest
//   upd_cf      out  instruction updates PSR C and F
//   upd_lnz     out  instruction updates PSR L, N and Z
//   illegal     out  instruction is undecodable
module instr_decode
    import alu_exec_ctrl_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 16
) (
    input  logic [15:0]           instr,
    output logic [3:0]            aluControl,
    output logic [DATA_WIDTH-1:0] imm,
    output logic                  a_imm_sel,
    output logic                  b_imm_sel,
    output logic                  writes_rf,
    output logic                  upd_cf,
    output logic                  upd_lnz,
    output logic                  illegal
);

    logic [3:0] opcode;
    logic [3:0] key;
    logic [7:0] imm8;
    logic       is_imm;
    logic       sext;
    logic       is_mov;

    assign opcode = instr[15:12];
    assign imm8   = instr[7:0];
    assign is_imm = (opcode != OP_RTYPE);
    // Both formats share one code space: ext for register format, opcode otherwise.
    assign key    = is_imm ? opcode : instr[7:4];

    always_comb begin
        aluControl = ALU_NOP;
        imm        = '0;
        a_imm_sel  = 1'b0;
        b_imm_sel  = 1'b0;
        writes_rf  = 1'b0;
        upd_cf     = 1'b0;
        upd_lnz    = 1'b0;
        illegal    = 1'b0;
        sext       = 1'b0;
        is_mov     = 1'b0;

        case (key)
            EXT_ADD: begin aluControl = ALU_ADD; writes_rf = 1'b1; upd_cf = 1'b1; sext = 1'b1; end
            EXT_SUB: begin aluControl = ALU_SUB; writes_rf = 1'b1; upd_cf = 1'b1; sext = 1'b1; end
            EXT_CMP: begin aluControl = ALU_CMP; upd_lnz = 1'b1; sext = 1'b1; end
            EXT_AND: begin aluControl = ALU_AND; writes_rf = 1'b1; end
            EXT_OR:  begin aluControl = ALU_OR;  writes_rf = 1'b1; end
            EXT_XOR: begin aluControl = ALU_XOR; writes_rf = 1'b1; end
            EXT_MOV: begin
                aluControl = is_imm ? ALU_MOVI : ALU_MOV;
                writes_rf  = 1'b1;
                is_mov     = 1'b1;
            end
            default: illegal = 1'b1;
        endcase

        if (is_imm && !illegal) begin
            imm = sext ? {{(DATA_WIDTH-8){imm8[7]}}, imm8} : {{(DATA_WIDTH-8){1'b0}}, imm8};
            // MOVI routes the immediate through b; every other immediate op uses a.
            if (is_mov) begin
                b_imm_sel = 1'b1;
            end else begin
                a_imm_sel = 1'b1;
            end
        end
    end

endmodule

// File: rtl/alu_exec_ctrl.sv
// Multicycle issue/writeback controller around the 16-bit ALU.
// Accepts one instruction per handshake, sequences IDLE -> DECODE ->
// EXECUTE -> WRITEBACK, and owns the processor status register.
// Ports:
//   clk, reset                 clock (rising edge), async active-low reset
//   instr, instr_valid         instruction word and its valid strobe
//   instr_ready                high in IDLE only
//   rf_raddr_a / rf_raddr_b    Rsrc / Rdest read addresses
//   imm, a_imm_sel, b_imm_sel  extended immediate and ALU operand selects
//   aluControl                 ALU operation code
//   alu_C/L/F/Z/N              ALU flag inputs
//   rf_we, rf_waddr            register write strobe and address (Rdest)
//   psr                        {N,Z,F,L,C}
//   illegal                    one-cycle pulse in WRITEBACK of a bad instruction
module alu_exec_ctrl
    import alu_exec_ctrl_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 16,
    parameter int unsigned ADDR_WIDTH = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [15:0]           instr,
    input  logic                  instr_valid,
    output logic                  instr_ready,
    output logic [ADDR_WIDTH-1:0] rf_raddr_a,
    output logic [ADDR_WIDTH-1:0] rf_raddr_b,
    output logic [DATA_WIDTH-1:0] imm,
    output logic                  a_imm_sel,
    output logic                  b_imm_sel,
    output logic [3:0]            aluControl,
    input  logic                  alu_C,
    input  logic                  alu_L,
    input  logic                  alu_F,
    input  logic                  alu_Z,
    input  logic                  alu_N,
    output logic                  rf_we,
    output logic [ADDR_WIDTH-1:0] rf_waddr,
    output logic [4:0]            psr,
    output logic                  illegal
);

    state_e state;
    state_e state_nxt;

    logic [15:0]           ir;
    logic [3:0]            dec_alu;
    logic [DATA_WIDTH-1:0] dec_imm;
    logic                  dec_asel;
    logic                  dec_bsel;
    logic                  dec_wr;
    logic                  dec_cf;
    logic                  dec_lnz;
    logic                  dec_ill;

    logic wr_q;
    logic cf_q;
    logic lnz_q;
    logic ill_q;

    instr_decode #(
        .DATA_WIDTH(DATA_WIDTH)
    ) u_decode (
        .instr      (ir),
        .aluControl (dec_alu),
        .imm        (dec_imm),
        .a_imm_sel  (dec_asel),
        .b_imm_sel  (dec_bsel),
        .writes_rf  (dec_wr),
        .upd_cf     (dec_cf),
        .upd_lnz    (dec_lnz),
        .illegal    (dec_ill)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        instr_ready = 1'b0;
        rf_we       = 1'b0;
        illegal     = 1'b0;
        case (state)
            ST_IDLE: begin
                instr_ready = 1'b1;
                if (instr_valid) begin
                    state_nxt = ST_DECODE;
                end
            end
            ST_DECODE:  state_nxt = ST_EXECUTE;
            ST_EXECUTE: state_nxt = ST_WRITEBACK;
            ST_WRITEBACK: begin
                rf_we     = wr_q;
                illegal   = ill_q;
                state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ir         <= '0;
            rf_raddr_a <= '0;
            rf_raddr_b <= '0;
            rf_waddr   <= '0;
            aluControl <= '0;
            imm        <= '0;
            a_imm_sel  <= 1'b0;
            b_imm_sel  <= 1'b0;
            wr_q       <= 1'b0;
            cf_q       <= 1'b0;
            lnz_q      <= 1'b0;
            ill_q      <= 1'b0;
            psr        <= '0;
        end else begin
            // Read addresses come straight from the accepted word so the
            // synchronous register file is addressed during DECODE.
            if (state == ST_IDLE && instr_valid) begin
                ir         <= instr;
                rf_raddr_a <= ADDR_WIDTH'(instr[3:0]);
                rf_raddr_b <= ADDR_WIDTH'(instr[11:8]);
                rf_waddr   <= ADDR_WIDTH'(instr[11:8]);
            end
            // Decode results are registered at the end of DECODE and held
            // through EXECUTE and WRITEBACK.
            if (state == ST_DECODE) begin
                aluControl <= dec_alu;
                imm        <= dec_imm;
                a_imm_sel  <= dec_asel;
                b_imm_sel  <= dec_bsel;
                wr_q       <= dec_wr;
                cf_q       <= dec_cf;
                lnz_q      <= dec_lnz;
                ill_q      <= dec_ill;
            end
            if (state == ST_WRITEBACK) begin
                if (cf_q) begin
                    psr[PSR_C] <= alu_C;
                    psr[PSR_F] <= alu_F;
                end
                if (lnz_q) begin
                    psr[PSR_L] <= alu_L;
                    psr[PSR_Z] <= alu_Z;
                    psr[PSR_N] <= alu_N;
                end
            end
        end
    end

endmodule
